// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the memory stage (master) and data memory (slave).
interface mem_stage_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemRData, MemAck
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, variable-latency data-memory access with timeout,
// MEM/WB register and write-back result / forwarding values.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWriteE,
    input  logic               MemtoRegE,
    input  logic               MemWriteE,
    input  logic [31:0]        ALUResultE,
    input  logic [31:0]        WriteDataE,
    input  logic [3:0]         RdE,
    mem_stage_if.master        mem,
    output logic               StallM,
    output logic               RegWriteM,
    output logic [3:0]         RdM,
    output logic [31:0]        ALUResultM,
    output logic               RegWriteW,
    output logic               MemtoRegW,
    output logic [3:0]         RdW,
    output logic [31:0]        ReadDataW,
    output logic [31:0]        ALUOutW,
    output logic [31:0]        ResultW,
    output logic               MemErr,
    output logic               ErrSticky
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic        mem_to_reg_m;
    logic        mem_write_m;
    logic [31:0] write_data_m;

    logic access_m, mis_m, good_m, ack_m, timeout_now, drop;

    // EX/MEM pipeline register; frozen while the access is outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteM    <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            ALUResultM   <= '0;
            write_data_m <= '0;
            RdM          <= '0;
        end else if (!StallM) begin
            RegWriteM    <= RegWriteE;
            mem_to_reg_m <= MemtoRegE;
            mem_write_m  <= MemWriteE;
            ALUResultM   <= ALUResultE;
            write_data_m <= WriteDataE;
            RdM          <= RdE;
        end
    end

    assign access_m    = mem_to_reg_m | mem_write_m;
    assign mis_m       = access_m & (ALUResultM[1:0] != 2'b00);
    assign good_m      = access_m & ~mis_m;
    assign ack_m       = good_m & mem.MemAck;
    assign timeout_now = good_m & ~mem.MemAck & (wait_cnt_q == LAST_CNT);
    assign StallM      = good_m & ~mem.MemAck & ~timeout_now;
    assign drop        = mis_m | timeout_now;

    assign mem.MemReq   = good_m;
    assign mem.MemWe    = mem_write_m;
    assign mem.MemAddr  = {ALUResultM[31:2], 2'b00};
    assign mem.MemWData = write_data_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Wait counter tracks how many request cycles have elapsed without an ack
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (good_m && !mem.MemAck) begin
                    state_d    = WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (ack_m || !good_m || (wait_cnt_q == LAST_CNT)) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // MEM/WB register; a stalled or dropped access retires as a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            RdW       <= '0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            MemErr    <= 1'b0;
            ErrSticky <= 1'b0;
        end else begin
            MemErr    <= drop;
            ErrSticky <= ErrSticky | drop;
            if (StallM) begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
            end else begin
                RegWriteW <= RegWriteM & ~drop;
                MemtoRegW <= mem_to_reg_m & ~drop;
                RdW       <= RdM;
                ALUOutW   <= ALUResultM;
                if (mem_to_reg_m && ack_m) begin
                    ReadDataW <= mem.MemRData;
                end
            end
        end
    end

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: instruction table driven through the stage with a
// per-row memory latency, scoreboard of in-flight rows, plus reset-mid-access sequence.
module tb_mem_stage;
    localparam int unsigned MW     = 4;
    localparam int          NV     = 11;
    localparam int          BUDGET = 400;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  rd;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_req;
        int          exp_stall;
        logic        exp_rww;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [3:0]  RdE;
    logic        StallM, RegWriteM, RegWriteW, MemtoRegW, MemErr, ErrSticky;
    logic [3:0]  RdM, RdW;
    logic [31:0] ALUResultM, ReadDataW, ALUOutW, ResultW;

    mem_stage_if mem ();

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteE  (RegWriteE),
        .MemtoRegE  (MemtoRegE),
        .MemWriteE  (MemWriteE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .mem        (mem),
        .StallM     (StallM),
        .RegWriteM  (RegWriteM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .RdW        (RdW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .ResultW    (ResultW),
        .MemErr     (MemErr),
        .ErrSticky  (ErrSticky)
    );

    int   checks = 0;
    int   passed = 0;
    vec_t vecs [NV];
    int   m_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h, required %h", name, act, exp);
    endtask

    task automatic set_e(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] rd);
        RegWriteE  = rw;
        MemtoRegE  = m2r;
        MemWriteE  = mw;
        ALUResultE = alu;
        WriteDataE = wd;
        RdE        = rd;
    endtask

    function automatic vec_t mk(input logic rw, input logic m2r, input logic mw,
                                input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] rd,
                                input int ack_at, input logic [31:0] rdata,
                                input int er, input int es,
                                input logic rww, input logic [31:0] res, input logic err);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.mw = mw; v.alu = alu; v.wd = wd; v.rd = rd;
        v.ack_at = ack_at; v.rdata = rdata; v.exp_req = er; v.exp_stall = es;
        v.exp_rww = rww; v.exp_res = res; v.exp_err = err;
        return v;
    endfunction

    initial begin
        int   e_idx, cyc_in_m, req_cnt, stall_cnt, left_row, leaving, r, guard, c, n;
        logic sticky_seen, err_now;

        //           rw    m2r   mw    alu           wd            rd    ack rdata         req st rww   result        err
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h55,       32'h0,        4'd1,  0, 32'h0,        0, 0, 1'b1, 32'h55,       1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h100,      32'h0,        4'd3,  1, 32'hDEADBEEF, 1, 0, 1'b1, 32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h204,      32'h12345678, 4'd5,  3, 32'h0,        3, 2, 1'b0, 32'h204,      1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 32'h102,      32'h0,        4'd4,  1, 32'h0BADBAD0, 0, 0, 1'b0, 32'h102,      1'b1);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h300,      32'h0,        4'd6,  0, 32'h0,        4, 3, 1'b0, 32'h300,      1'b1);
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h304,      32'h0,        4'd7,  4, 32'hCAFEF00D, 4, 3, 1'b1, 32'hCAFEF00D, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'hA5A5,     32'h0,        4'd8,  0, 32'h0,        0, 0, 1'b1, 32'hA5A5,     1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'h10,       32'h0,        4'd9,  1, 32'h1111,     1, 0, 1'b1, 32'h1111,     1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h400,      32'hFEED,     4'd10, 1, 32'h0,        1, 0, 1'b1, 32'h400,      1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 32'h8,        32'h0,        4'd11, 2, 32'h2222,     2, 1, 1'b1, 32'h2222,     1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'h401,      32'hBEEF,     4'd0,  1, 32'h0,        0, 0, 1'b0, 32'h401,      1'b1);

        reset = 1'b1;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        mem.MemAck   = 1'b0;
        mem.MemRData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq",    32'(mem.MemReq), 32'd0);
        chk("rst_stallm",    32'(StallM),     32'd0);
        chk("rst_regwritew", 32'(RegWriteW),  32'd0);
        chk("rst_resultw",   ResultW,         32'd0);
        chk("rst_memerr",    32'(MemErr),     32'd0);
        chk("rst_errsticky", 32'(ErrSticky),  32'd0);
        chk("rst_rdw",       32'(RdW),        32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        e_idx = 0; cyc_in_m = 0; req_cnt = 0; stall_cnt = 0;
        left_row = -1; sticky_seen = 1'b0; guard = 0;
        while ((e_idx < NV || m_q.size() != 0 || left_row >= 0) && guard < BUDGET) begin
            guard++;
            @(posedge clk); #1;
            if (e_idx < NV)
                set_e(vecs[e_idx].rw, vecs[e_idx].m2r, vecs[e_idx].mw,
                      vecs[e_idx].alu, vecs[e_idx].wd, vecs[e_idx].rd);
            else
                set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
            c = cyc_in_m + 1;
            if (m_q.size() != 0 && (vecs[m_q[0]].m2r || vecs[m_q[0]].mw) &&
                vecs[m_q[0]].alu[1:0] == 2'b00) begin
                mem.MemAck   = (vecs[m_q[0]].ack_at == c);
                mem.MemRData = mem.MemAck ? vecs[m_q[0]].rdata : $urandom;
            end else begin
                // no request outstanding: ack noise must be ignored
                mem.MemAck   = 1'($urandom_range(0, 1));
                mem.MemRData = $urandom;
            end

            @(negedge clk);
            err_now = 1'b0;
            if (left_row >= 0) begin
                chk($sformatf("row%0d_regwritew", left_row), 32'(RegWriteW), 32'(vecs[left_row].exp_rww));
                chk($sformatf("row%0d_rdw", left_row),       32'(RdW),       32'(vecs[left_row].rd));
                chk($sformatf("row%0d_resultw", left_row),   ResultW,        vecs[left_row].exp_res);
                chk($sformatf("row%0d_memerr", left_row),    32'(MemErr),    32'(vecs[left_row].exp_err));
                err_now = vecs[left_row].exp_err;
            end else begin
                chk("bubble_regwritew", 32'(RegWriteW), 32'd0);
                chk("bubble_memerr",    32'(MemErr),    32'd0);
            end
            if (!err_now) chk("errsticky", 32'(ErrSticky), 32'(sticky_seen));
            else sticky_seen = 1'b1;

            leaving = -1;
            if (m_q.size() != 0) begin
                r = m_q[0];
                if (cyc_in_m == 0) begin
                    chk($sformatf("row%0d_aluresultm", r), ALUResultM,     vecs[r].alu);
                    chk($sformatf("row%0d_rdm", r),        32'(RdM),       32'(vecs[r].rd));
                    chk($sformatf("row%0d_regwritem", r),  32'(RegWriteM), 32'(vecs[r].rw));
                end
                if (mem.MemReq) begin
                    req_cnt++;
                    chk($sformatf("row%0d_memaddr", r),  mem.MemAddr,     vecs[r].alu & 32'hFFFF_FFFC);
                    chk($sformatf("row%0d_memwe", r),    32'(mem.MemWe),  32'(vecs[r].mw));
                    chk($sformatf("row%0d_memwdata", r), mem.MemWData,    vecs[r].wd);
                end
                if (StallM) stall_cnt++;
                if (!StallM) begin
                    chk($sformatf("row%0d_req_cycles", r),   32'(req_cnt),   32'(vecs[r].exp_req));
                    chk($sformatf("row%0d_stall_cycles", r), 32'(stall_cnt), 32'(vecs[r].exp_stall));
                    leaving = r;
                    void'(m_q.pop_front());
                    cyc_in_m = 0; req_cnt = 0; stall_cnt = 0;
                end else begin
                    cyc_in_m++;
                end
            end else begin
                chk("nop_memreq", 32'(mem.MemReq), 32'd0);
                chk("nop_stallm", 32'(StallM),     32'd0);
            end
            if (!StallM && e_idx < NV) begin
                m_q.push_back(e_idx);
                e_idx++;
            end
            left_row = leaving;
        end
        chk("table_drained", 32'(guard < BUDGET), 32'd1);

        // Reset asserted while a load waits in its third request cycle
        @(posedge clk); #1;
        mem.MemAck = 1'b0;
        set_e(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 4'd2);
        @(posedge clk); #1;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("wait_memreq", 32'(mem.MemReq), 32'd1);
        chk("wait_stallm", 32'(StallM),     32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_memreq",    32'(mem.MemReq), 32'd0);
        chk("midrst_stallm",    32'(StallM),     32'd0);
        chk("midrst_regwritew", 32'(RegWriteW),  32'd0);
        chk("midrst_errsticky", 32'(ErrSticky),  32'd0);
        @(posedge clk); #1;
        reset        = 1'b0;
        mem.MemAck   = 1'b1;
        mem.MemRData = 32'h77;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_ack_memreq",    32'(mem.MemReq), 32'd0);
            chk("late_ack_stallm",    32'(StallM),     32'd0);
            chk("late_ack_regwritew", 32'(RegWriteW),  32'd0);
            chk("late_ack_resultw",   ResultW,         32'd0);
            chk("late_ack_memerr",    32'(MemErr),     32'd0);
        end

        // A fresh unacked load must wait the full MAX_WAIT cycles again
        @(posedge clk); #1;
        mem.MemAck = 1'b0;
        set_e(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 4'd12);
        @(posedge clk); #1;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem.MemReq) n++;
        end
        chk("post_rst_timeout_req_cycles", 32'(n), 32'(MW));
        chk("post_rst_errsticky", 32'(ErrSticky), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
